// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes, FSM states and
// the counter-width helper.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Unsigned iterative datapath: right-shifting shift-add multiply (mode 0) or
// restoring divide (mode 1). hi/lo hold product halves or remainder/quotient.
module seq_alu_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] rem_diff;
  logic             fits;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh   = {hi_q, lo_q[WIDTH-1]};
    rem_diff = {1'b0, rem_sh} - {2'b00, b_q};
    fits     = ~rem_diff[WIDTH+1];
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    b_d  = b_q;
    if (load_i) begin
      hi_d = '0;
      lo_d = opa_i;
      b_d  = opb_i;
    end else if (step_i) begin
      if (!mode_i) begin
        // carry of the partial sum shifts into the top of hi
        hi_d = mul_sum[WIDTH:1];
        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end else begin
        hi_d = fits ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], fits};
      end
    end
  end

  always_ff @(posedge clk) begin
    hi_q <= hi_d;
    lo_q <= lo_d;
    b_q  <= b_d;
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle signed ALU (ADD/SUB/MUL/DIV) with start/done handshake;
// sign handling, flags and control live here, iteration in seq_alu_iter.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             dbz
);

  localparam int CNT_W = clog2(WIDTH + 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [1:0]              op_q;
  logic signed [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0]        lo_q, lo_d, hi_q, hi_d;
  logic                    carry_q, carry_d, ovf_q, ovf_d;
  logic                    zero_q, zero_d, neg_q, neg_d, dbz_q, dbz_d;

  logic                    busy_w, accept, it_load, it_step;
  logic [WIDTH-1:0]        it_hi, it_lo, addb;
  logic [WIDTH:0]          sum;
  logic [2*WIDTH-1:0]      prod_u, prod_s;
  logic [WIDTH-1:0]        quo_s, rem_s;
  logic                    sgn_diff;

  // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is exact as an unsigned magnitude
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  assign busy_w  = (state_q == EXEC) || (state_q == ITER) || (state_q == FIX);
  assign accept  = start && !busy_w;
  assign it_load = (state_q == ITER) && (cnt_q == '0);
  assign it_step = (state_q == ITER) && (cnt_q != '0);

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .load_i (it_load),
    .step_i (it_step),
    .mode_i (op_q == OP_DIV),
    .opa_i  (mag(a_q)),
    .opb_i  (mag(b_q)),
    .hi_o   (it_hi),
    .lo_o   (it_lo)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start)
          state_d = ((op == OP_MUL) || ((op == OP_DIV) && (b != '0))) ? ITER : EXEC;
        else
          state_d = IDLE;
      end
      EXEC:    state_d = DONE;
      ITER:    if (cnt_q == CNT_W'(WIDTH)) state_d = FIX;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addb     = (op_q == OP_SUB) ? ~b_q : b_q;
    sum      = {1'b0, a_q} + {1'b0, addb} + (WIDTH+1)'(op_q == OP_SUB);
    sgn_diff = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    prod_u   = {it_hi, it_lo};
    prod_s   = sgn_diff ? (~prod_u + 1'b1) : prod_u;
    quo_s    = sgn_diff ? (~it_lo + 1'b1) : it_lo;
    rem_s    = a_q[WIDTH-1] ? (~it_hi + 1'b1) : it_hi;
  end

  always_comb begin
    lo_d    = '0;
    hi_d    = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    dbz_d   = 1'b0;
    if (state_q == EXEC) begin
      if (op_q == OP_DIV) begin
        lo_d  = '1;
        hi_d  = a_q;
        dbz_d = 1'b1;
      end else begin
        lo_d    = sum[WIDTH-1:0];
        hi_d    = {WIDTH{sum[WIDTH-1]}};
        carry_d = sum[WIDTH];
        ovf_d   = (a_q[WIDTH-1] == addb[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
    end else if (op_q == OP_MUL) begin
      lo_d  = prod_s[WIDTH-1:0];
      hi_d  = prod_s[2*WIDTH-1:WIDTH];
      ovf_d = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
    end else begin
      lo_d  = quo_s;
      hi_d  = rem_s;
      // only -2^(WIDTH-1) / -1 yields a positive quotient with the MSB set
      ovf_d = !sgn_diff && it_lo[WIDTH-1];
    end
    zero_d = (op_q == OP_MUL) ? ({hi_d, lo_d} == '0) : (lo_d == '0);
    neg_d  = (op_q == OP_MUL) ? hi_d[WIDTH-1] : lo_d[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      lo_q    <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op;
        cnt_q <= '0;
      end else if (state_q == ITER) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // results register on the transition into DONE and hold until the next one
      if ((state_q == EXEC) || (state_q == FIX)) begin
        lo_q    <= lo_d;
        hi_q    <= hi_d;
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
        zero_q  <= zero_d;
        neg_q   <= neg_d;
        dbz_q   <= dbz_d;
      end
    end
  end

  assign busy      = busy_w;
  assign done      = (state_q == DONE);
  assign result_lo = lo_q;
  assign result_hi = hi_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign dbz       = dbz_q;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised multi-cycle signed ALU that replaces the standalone combinational 8-bit adder/subtractor pair.
- Adds iterative multiply (shift-add) and divide (restoring) to ADD/SUB, with status flags.
- Uses a start/done handshake so a controller can issue operations back to back.
- Sits between the operand register file and the result writeback stage.

Parameters:
WIDTH, 8, operand width in bits (two's complement), must be >= 4.

Ports:
clk        input   1        rising-edge clock
rst_n      input   1        asynchronous active-low reset
start      input   1        request; accepted only when busy=0
op         input   2        00 ADD, 01 SUB, 10 MUL, 11 DIV (sampled with start)
a          input   WIDTH    signed operand A / dividend (sampled with start)
b          input   WIDTH    signed operand B / divisor (sampled with start)
busy       output  1        operation in progress
done       output  1        one-cycle pulse, results valid
result_lo  output  WIDTH    ADD/SUB result; MUL product low half; DIV quotient
result_hi  output  WIDTH    ADD/SUB sign extension; MUL product high half; DIV remainder
carry      output  1        ADD: carry out; SUB: carry of a+~b+1 (1 = no borrow); else 0
ovf        output  1        signed overflow (see below)
zero       output  1        ADD/SUB/DIV: result_lo==0; MUL: full product==0
neg        output  1        MSB of result_lo (ADD/SUB/DIV) or result_hi (MUL)
dbz        output  1        divide by zero

Behaviour:
- Reset (async assert, sync release) forces state IDLE and all outputs to 0; an in-flight operation is discarded and no done is issued.
- FSM states: IDLE -> (start & ~busy) -> EXEC (ADD/SUB, or DIV with b==0) or ITER (MUL/DIV).
  - EXEC -> DONE after 1 cycle.
  - ITER runs WIDTH cycles -> FIX (sign correction) -> DONE.
  - DONE -> IDLE.
- Latency, counting edges from acceptance edge 0: done is high for exactly one cycle.
  - ADD/SUB/DIV-by-zero: done on the cycle after edge 1.
  - MUL/DIV: done on the cycle after edge WIDTH+2.
- busy is high from edge 0 through the FIX state and is low in the DONE cycle.
- Back-to-back: start in the DONE cycle is accepted.
- start while busy=1 is ignored; no queueing.
- Outputs hold their values until the next done. Operands are captured at acceptance; changes to a/b/op afterwards are ignored.
- ADD/SUB: WIDTH+1-bit sum. ovf = operand sign agreement with result sign mismatch (standard signed rule).
- MUL:
  - Datapath: magnitudes of a and b, unsigned shift-add over WIDTH iterations, 2*WIDTH-bit product, negated in FIX if the signs differ.
  - ovf=1 if the product is not representable in WIDTH signed bits.
- DIV:
  - Datapath: restoring division on magnitudes.
  - Quotient is truncated toward zero. Remainder takes the sign of the dividend.
  - b==0: dbz=1, result_lo = all ones, result_hi = a, ovf=0.
  - a = -2^(WIDTH-1) with b = -1: result_lo = a, result_hi = 0, ovf=1.
- Magnitude of -2^(WIDTH-1) needs a WIDTH-bit unsigned magnitude register; no truncation is permitted.
- carry=0 for MUL/DIV. dbz=0 except DIV by zero.

Decomposition:
- Package alu_pkg:
  - op encoding localparams (OP_ADD, OP_SUB, OP_MUL, OP_DIV);
  - FSM state encoding (IDLE, EXEC, ITER, FIX, DONE);
  - iteration counter width function clog2(WIDTH+1).
- Sub-module seq_alu_iter:
  - unsigned WIDTH-iteration shift-add / restoring-divide datapath with load/step/mode inputs;
  - top handles sign, flags, FSM.

Test Plan (WIDTH=8):
1. ADD a=127, b=1 -> result_lo=0x80, result_hi=0xFF, ovf=1, carry=0, neg=1; done 1 cycle after edge 1.
2. SUB a=10, b=20 -> result_lo=0xF6, carry=0, ovf=0, neg=1; then SUB a=15, b=10 -> 0x05, carry=1.
3. MUL a=-50, b=30 -> {hi,lo}=16'hFA24 (-1500), ovf=1, neg=1; done exactly after edge 10. MUL a=-128, b=-128 -> 16'h4000, ovf=1.
4. DIV a=-100, b=7 -> result_lo=0xF2 (-14), result_hi=0xFE (-2). DIV a=-128, b=-1 -> result_lo=0x80, result_hi=0, ovf=1.
5. DIV a=50, b=0 -> dbz=1, result_lo=0xFF, result_hi=0x32; done after edge 1. Next op ADD 1+1 clears dbz.
6. Handshake and reset:
   - start pulses during a MUL are ignored (exactly one done);
   - start in the DONE cycle is accepted;
   - rst_n low mid-MUL (edge 4) -> all outputs 0, no done;
   - a fresh MUL after release completes correctly.
